shake_parse_ntt: RTL and testbench



---
 rtl/shake_parse_ntt.sv | 168 ++++++++++++++++
 tb/tb_shake_parse_ntt.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_parse_ntt.sv
// Kyber Parse / SampleNTT: rejection-samples 12-bit candidates (< Q) from SHAKE-128 squeeze blocks.
// Latency: block capture -> first evaluation 1 cycle; coef outputs registered 1 cycle after evaluation.
// Backpressure: pulls blocks via blk_valid/blk_ready; the coef output has none (one coef per cycle max).
//
// Ports:
//   clk, rst (sync, active-low), start (new polynomial, honoured in IDLE/DONE)
//   blk_in/blk_valid/blk_ready : squeeze block handshake; byte k = blk_in[8k +: 8], blk_in[8k] is its MSB
//   more_req                   : level request to the XOF for another squeeze block
//   coef_valid/coef_idx/coef   : accepted coefficient stream, indices 0..N_COEF-1
//   busy, done                 : polynomial in progress / complete (done held until next start)
// Optional macro PARSE_REJECT_CNT_EN adds rej_cnt[15:0], a saturating count of rejected candidates.
module shake_parse_ntt #(
  parameter int Q       = 3329,
  parameter int N_COEF  = 256,
  parameter int R_BYTES = 168,
  parameter int COEF_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:8*R_BYTES-1]   blk_in,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic                   more_req,
  output logic                   coef_valid,
  output logic [7:0]             coef_idx,
  output logic [COEF_W-1:0]      coef,
  output logic                   busy,
  output logic                   done
`ifdef PARSE_REJECT_CNT_EN
  ,
  output logic [15:0]            rej_cnt
`endif
);

  localparam int GROUPS = R_BYTES / 3;
  localparam int G_W    = $clog2(GROUPS + 1);
  localparam int CNT_W  = $clog2(N_COEF + 1);
  localparam logic [COEF_W-1:0] Q_C = COEF_W'(Q);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    D1       = 3'd2,
    D2       = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e                 state_q;
  logic [0:8*R_BYTES-1]   blk_q;
  logic [G_W-1:0]         g_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   blk_ready_q;
  logic                   more_req_q;
  logic                   coef_valid_q;
  logic [7:0]             coef_idx_q;
  logic [COEF_W-1:0]      coef_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef PARSE_REJECT_CNT_EN
  logic [15:0]            rej_q;
`endif

  // Current 3-byte group, selected by the group index.
  logic [7:0]        b0, b1, b2;
  logic [COEF_W-1:0] cand;
  logic              accept;
  logic              last_coef;
  int                base;

  always_comb begin
    base = 24 * int'(g_q);
    b0   = blk_q[base      +: 8];
    b1   = blk_q[base + 8  +: 8];
    b2   = blk_q[base + 16 +: 8];
    // D1 takes byte0 plus the low nibble of byte1; D2 takes the high nibble of byte1 plus byte2.
    if (state_q == D1) cand = {b1[3:0], b0};
    else               cand = {b2, b1[7:4]};
    accept    = (cand < Q_C);
    last_coef = (cnt_q == CNT_W'(N_COEF - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      g_q          <= '0;
      cnt_q        <= '0;
      blk_ready_q  <= 1'b0;
      more_req_q   <= 1'b0;
      coef_valid_q <= 1'b0;
      coef_idx_q   <= '0;
      coef_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PARSE_REJECT_CNT_EN
      rej_q        <= '0;
`endif
    end else begin
      coef_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= WAIT_BLK;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            blk_ready_q <= 1'b1;
            more_req_q  <= 1'b1;
`ifdef PARSE_REJECT_CNT_EN
            rej_q       <= '0;
`endif
          end
        end
        WAIT_BLK: begin
          if (blk_valid && blk_ready_q) begin
            blk_q       <= blk_in;
            g_q         <= '0;
            state_q     <= D1;
            blk_ready_q <= 1'b0;
            more_req_q  <= 1'b0;
          end
        end
        D1, D2: begin
          if (accept) begin
            coef_valid_q <= 1'b1;
            coef_q       <= cand;
            coef_idx_q   <= cnt_q[7:0];
            cnt_q        <= cnt_q + CNT_W'(1);
          end
`ifdef PARSE_REJECT_CNT_EN
          else if (rej_q != 16'hFFFF) begin
            rej_q <= rej_q + 16'd1;
          end
`endif
          if (accept && last_coef) begin
            // Remaining bytes of this block are dropped; no further block is requested.
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (state_q == D1) begin
            state_q <= D2;
          end else if (g_q == G_W'(GROUPS - 1)) begin
            state_q     <= WAIT_BLK;
            blk_ready_q <= 1'b1;
            more_req_q  <= 1'b1;
          end else begin
            g_q     <= g_q + G_W'(1);
            state_q <= D1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_ready  = blk_ready_q;
  assign more_req   = more_req_q;
  assign coef_valid = coef_valid_q;
  assign coef_idx   = coef_idx_q;
  assign coef       = coef_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef PARSE_REJECT_CNT_EN
  assign rej_cnt    = rej_q;
`endif

endmodule

// File: tb/tb_shake_parse_ntt.sv
// Bench for shake_parse_ntt: table of single-group blocks plus hand-written polynomial sequences.
// Expected coefficients are queued when a block is driven and compared as the DUT emits them.
// Runs standalone; with PARSE_REJECT_CNT_EN defined the reject counter is checked as well.
module tb_shake_parse_ntt;

  localparam int RB = 168;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [0:8*RB-1]   blk_in;
  logic              blk_valid;
  logic              blk_ready;
  logic              more_req;
  logic              coef_valid;
  logic [7:0]        coef_idx;
  logic [11:0]       coef;
  logic              busy;
  logic              done;
`ifdef PARSE_REJECT_CNT_EN
  logic [15:0]       rej_cnt;
`endif

  shake_parse_ntt dut (
    .clk(clk), .rst(rst), .start(start),
    .blk_in(blk_in), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .more_req(more_req), .coef_valid(coef_valid), .coef_idx(coef_idx),
    .coef(coef), .busy(busy), .done(done)
`ifdef PARSE_REJECT_CNT_EN
    , .rej_cnt(rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] idx; logic [11:0] c; } exp_t;
  typedef struct { logic [7:0] b0, b1, b2; int n; logic [11:0] c0, c1; } vec_t;

  exp_t            sb[$];
  exp_t            e;
  bit              exp_last;
  int              nchk = 0;
  int              nerr = 0;
  int              popped = 0;
  logic [0:8*RB-1] zeros = '0;
  logic [0:8*RB-1] ones  = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard side: every emitted coefficient must match the head of the queue.
  always @(negedge clk) begin
    if (coef_valid) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_coef: got idx=%0d coef=%0d, required no output", coef_idx, coef);
      end else begin
        e = sb.pop_front();
        exp_last = (e.idx == 8'd255);
        if (coef !== e.c || coef_idx !== e.idx || done !== exp_last || busy !== !exp_last) begin
          nerr++;
          $display("FAIL coef_stream: got idx=%0d coef=%0d done=%0d busy=%0d, required idx=%0d coef=%0d done=%0d busy=%0d",
                   coef_idx, coef, done, busy, e.idx, e.c, exp_last, !exp_last);
        end
        popped++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; blk_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    sb.delete();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_blk_ready"},  blk_ready,  0);
    chk({tag, "_more_req"},   more_req,   0);
    chk({tag, "_coef_valid"}, coef_valid, 0);
    chk({tag, "_coef_idx"},   coef_idx,   0);
    chk({tag, "_coef"},       coef,       0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
`ifdef PARSE_REJECT_CNT_EN
    chk({tag, "_rej_cnt"},    rej_cnt,    0);
`endif
  endtask

  // Offers one block and returns after the capturing edge; blk_in goes to garbage afterwards.
  task automatic send_block(input logic [0:8*RB-1] b, output bit ok);
    ok = 1'b0; blk_in = b; blk_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (blk_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    blk_valid = 1'b0; blk_in = ones;
  endtask

  // Cycles from the capture edge until blk_ready returns.
  task automatic count_eval(output int cyc);
    cyc = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (blk_ready) break;
    end
  endtask

  // blk_valid held high throughout; blk_in is garbage whenever the DUT is not ready, so any
  // sampling outside WAIT_BLK would corrupt the zero coefficient stream.
  task automatic run_zero(input bit poke, input int rst_at, output int caps, output bit fin, output bit got_rst);
    caps = 0; fin = 1'b0; got_rst = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk); #1;
      if (done) begin fin = 1'b1; break; end
      if (rst_at > 0 && popped >= rst_at) begin got_rst = 1'b1; break; end
      blk_valid = 1'b1;
      blk_in    = blk_ready ? zeros : ones;
      if (blk_ready) caps++;
      start     = poke && busy && (t % 29 == 7);
    end
    blk_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t            vecs[8];
    logic [0:8*RB-1] blk;
    bit              ok, fin, got_rst;
    int              cyc, caps;

    vecs[0] = '{8'h01, 8'h0D, 8'h0D, 1, 12'd208,  12'd0};    // d1 == Q rejected
    vecs[1] = '{8'h00, 8'h0D, 8'hD0, 2, 12'd3328, 12'd3328}; // both Q-1
    vecs[2] = '{8'h00, 8'h00, 8'h00, 2, 12'd0,    12'd0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 0, 12'd0,    12'd0};    // 4095 twice
    vecs[4] = '{8'h34, 8'h12, 8'h00, 2, 12'd564,  12'd1};
    vecs[5] = '{8'h00, 8'hF0, 8'hFF, 1, 12'd0,    12'd0};
    vecs[6] = '{8'hFF, 8'h0C, 8'hD0, 2, 12'd3327, 12'd3328};
    vecs[7] = '{8'h00, 8'h1E, 8'hD0, 0, 12'd0,    12'd0};    // 3584 and 3329

    rst = 1'b0; start = 1'b0; blk_valid = 1'b0; blk_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Table: one group of interest at the front of an otherwise all-0xFF block.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      popped = 0;
      pulse_start();
      chk($sformatf("vec%0d_start_ready", i), blk_ready, 1);
      chk($sformatf("vec%0d_start_more_req", i), more_req, 1);
      chk($sformatf("vec%0d_start_busy", i), busy, 1);
      blk = ones;
      blk[0:7]   = vecs[i].b0;
      blk[8:15]  = vecs[i].b1;
      blk[16:23] = vecs[i].b2;
      if (vecs[i].n >= 1) sb.push_back('{8'd0, vecs[i].c0});
      if (vecs[i].n >= 2) sb.push_back('{8'd1, vecs[i].c1});
      send_block(blk, ok);
      chk($sformatf("vec%0d_capture", i), ok, 1);
      count_eval(cyc);
      chk($sformatf("vec%0d_eval_cycles", i), cyc, 112);
      chk($sformatf("vec%0d_more_req_again", i), more_req, 1);
      chk($sformatf("vec%0d_coef_count", i), popped, vecs[i].n);
      chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
`ifdef PARSE_REJECT_CNT_EN
      chk($sformatf("vec%0d_rej_cnt", i), rej_cnt, 112 - vecs[i].n);
`endif
    end

    // All-zero polynomial: three blocks, 112 + 112 + 32 coefficients.
    do_reset();
    popped = 0;
    for (int i = 0; i < 256; i++) sb.push_back('{i[7:0], 12'd0});
    pulse_start();
    run_zero(1'b0, 0, caps, fin, got_rst);
    chk("zero_done_seen", fin, 1);
    chk("zero_captures", caps, 3);
    chk("zero_coefs", popped, 256);
    chk("zero_more_req_after", more_req, 0);
    chk("zero_blk_ready_after", blk_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_done_held", done, 1);
    chk("zero_busy_low", busy, 0);
    chk("zero_more_req_held_low", more_req, 0);
`ifdef PARSE_REJECT_CNT_EN
    chk("zero_rej_cnt", rej_cnt, 0);
`endif

    // Restart from DONE with an all-0xFF block: nothing emitted, back to waiting.
    popped = 0;
    pulse_start();
    chk("ff_done_cleared", done, 0);
    chk("ff_busy", busy, 1);
    send_block(ones, ok);
    chk("ff_capture", ok, 1);
    count_eval(cyc);
    chk("ff_eval_cycles", cyc, 112);
    chk("ff_more_req", more_req, 1);
    chk("ff_no_coefs", popped, 0);
`ifdef PARSE_REJECT_CNT_EN
    chk("ff_rej_cnt", rej_cnt, 112);
`endif

    // start pulses while busy and blk_valid held high: stream must be unchanged.
    do_reset();
    popped = 0;
    for (int i = 0; i < 256; i++) sb.push_back('{i[7:0], 12'd0});
    pulse_start();
    run_zero(1'b1, 0, caps, fin, got_rst);
    chk("poke_done_seen", fin, 1);
    chk("poke_captures", caps, 3);
    chk("poke_coefs", popped, 256);
    chk("poke_sb_empty", sb.size(), 0);

    // Reset after 50 coefficients, then a fresh polynomial from index 0.
    do_reset();
    popped = 0;
    for (int i = 0; i < 256; i++) sb.push_back('{i[7:0], 12'd0});
    pulse_start();
    run_zero(1'b0, 50, caps, fin, got_rst);
    chk("midrst_reached_50", got_rst, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    popped = 0;
    for (int i = 0; i < 256; i++) sb.push_back('{i[7:0], 12'd0});
    pulse_start();
    run_zero(1'b0, 0, caps, fin, got_rst);
    chk("midrst_done_seen", fin, 1);
    chk("midrst_coefs", popped, 256);
    chk("midrst_captures", caps, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
